uart_rx_deframer: RTL
=====================

// Module: uart_rx_deframer
// PURPOSE
//   Receive-side partner of the UART transmitter; consumes its serial line directly.
//   Oversamples RX_IN at PRESCALE clocks per bit and reconstructs the frame:
//   start(0), DATA_WIDTH bits LSB-first, optional parity, stop(1).
//   Frame fields match the TX side. Output is parallel word + 1-cycle Data_valid.
//   Framing errors and parity errors are flagged, not delivered.
// PARAMETERS
//   PRESCALE    8  clocks per bit; even, >=4 (>=6 with majority vote)
//   DATA_WIDTH  8  payload bits per frame
// PORTS
//   CLK         in   1           single clock
//   RST         in   1           synchronous, active-high reset
//   RX_IN       in   1           serial line, idle high; asynchronous to CLK
//   PAR_EN      in   1           1 = parity bit present
//   PAR_TYP     in   1           0 = even, 1 = odd
//   P_DATA      out  DATA_WIDTH  last good received word
//   Data_valid  out  1           1-cycle pulse, P_DATA updated
//   par_err     out  1           1-cycle pulse, parity mismatch
//   stp_err     out  1           1-cycle pulse, stop bit sampled 0
// BEHAVIOUR
//   - Reset: all outputs 0; FSM=IDLE; counters 0. RST mid-frame aborts with no pulse.
//   - RX_IN passes a 2-flop synchronizer (rx_s); a third flop holds rx_s_d for edge detection.
//   - Counters: edge_cnt 0..PRESCALE-1 wraps per bit; bit_cnt counts data bits.
//   - Sample point: edge_cnt == PRESCALE/2.
//   - PAR_EN and PAR_TYP are latched on start detection and held for the whole frame.
//   - FSM states and transitions:
//     IDLE:   rx_s==0 && rx_s_d==1 (falling edge) -> START; edge_cnt cleared.
//     START:  at sample point, 1 -> IDLE (glitch reject, no flag); 0 -> DATA at bit end.
//     DATA:   shift sample into shreg[bit_cnt] (LSB first).
//             After DATA_WIDTH bits -> PARITY if PAR_EN, else STOP.
//     PARITY: at sample point compare with ^shreg ^ PAR_TYP.
//             Mismatch: remember it. Then -> STOP at bit end.
//     STOP:   at sample point:
//             - stop=1, no parity error: P_DATA<=shreg, Data_valid=1 next cycle.
//             - stop=1, parity error: par_err=1 instead.
//             - stop=0: stp_err=1; par_err is suppressed.
//             -> IDLE immediately; do not wait out the bit, so back-to-back frames are caught.
//   - Only one of Data_valid, par_err, stp_err pulses per frame.
//   - P_DATA holds its value until the next good frame.
//   - After stp_err, IDLE still requires a fresh 1->0 edge; a stuck-low line never re-triggers.
//   - Latency: Data_valid is 3 clocks after the stop-bit mid-sample edge reaches RX_IN
//     (2 sync + 1 reg).
// CONFIGURATION
//   UART_RX_MAJORITY_VOTE_EN defined:
//     each bit value is the 2-of-3 majority of samples at PRESCALE/2-1, PRESCALE/2, PRESCALE/2+1.
//     Start-glitch rejection uses the vote. Bit decision is available one cycle later.
//   Undefined: single sample at PRESCALE/2.
//   Frame timing, outputs and latency are otherwise identical in both builds.
// STRUCTURE
//   Package uart_pkg:
//     - rx_state_e {IDLE, START, DATA, PARITY, STOP}
//     - PAR_EVEN/PAR_ODD constants
//     - function par_calc(data, typ), shared with the TX parity logic
//   Sub-module uart_rx_sampler:
//     - synchronizer, edge_cnt, sample/vote logic
//     - outputs bit_val, bit_strobe (sample point) and bit_end (edge_cnt wrap)
//   The FSM, shift register and flags live in uart_rx_deframer.
// TESTING
//   Bench drives RX_IN from the TX block, or a behavioural model at PRESCALE=8.
//   1. PAR_EN=0, send 0xA5 -> P_DATA=0xA5, Data_valid one cycle, par_err=stp_err=0.
//   2. PAR_EN=1, PAR_TYP=0, send 0x3C with parity bit 0 -> Data_valid, P_DATA=0x3C.
//      Resend with parity bit 1 -> par_err pulse, no Data_valid, P_DATA stays 0x3C.
//   3. Send 0x81, force stop bit 0 -> stp_err only.
//      Hold line low 5 bit times, then release -> no further frames.
//   4. RX_IN low for 2 clocks then high -> no START completion, all outputs 0.
//   5. Back-to-back 0x00 then 0xFF with zero idle gap -> two Data_valid pulses, values in order.
//   6. RST asserted mid-DATA of 0x5A -> no pulse. Next frame 0x12 -> received correctly.
//      With UART_RX_MAJORITY_VOTE_EN: a 1-clock glitch at the bit-3 mid-sample is still received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: types and helpers shared by the UART receive and transmit paths.
//   rx_state_e - receive deframer FSM states
//   PAR_EVEN / PAR_ODD - encodings of the PAR_TYP input
//   par_calc   - parity bit the transmitter appends for a given word and type
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Widest payload par_calc accepts; narrower words are zero-extended,
  // which leaves the XOR reduction unchanged.
  localparam int unsigned UART_PAR_W = 32;

  // Expected parity bit: even -> ^data, odd -> ~^data.
  function automatic logic par_calc(input logic [UART_PAR_W-1:0] data,
                                    input logic                  typ);
    return (^data) ^ (typ == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: synchronises RX_IN, tracks the position inside a bit and
// decides each bit value.
//   CLK, RST      clock, synchronous active-high reset
//   RX_IN         asynchronous serial line (idle high)
//   i_start       load the bit counter for a new frame (falling edge taken)
//   i_run         frame in progress; counter free-runs, else held at 0
//   o_fall        1->0 transition on the synchronised line
//   o_bit_val     decided value of the current bit
//   o_bit_strobe  o_bit_val is valid this cycle
//   o_bit_end     last clock of the current bit
// Build option: UART_RX_MAJORITY_VOTE_EN selects a 2-of-3 vote over the
// samples at PRESCALE/2-1, PRESCALE/2, PRESCALE/2+1 (decision one cycle
// later); otherwise a single sample at PRESCALE/2 is used.
module uart_rx_sampler #(
  parameter int unsigned PRESCALE = 8
) (
  input  logic CLK,
  input  logic RST,
  input  logic RX_IN,
  input  logic i_start,
  input  logic i_run,
  output logic o_fall,
  output logic o_bit_val,
  output logic o_bit_strobe,
  output logic o_bit_end
);

  localparam int unsigned CNT_W = $clog2(PRESCALE);

  logic             r_rx_meta;
  logic             r_rx_s;
  logic             r_rx_s_d;
  logic [CNT_W-1:0] r_edge_cnt;

  // Synchroniser plus edge-detect flop; reset to the idle-high line level.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_s_d  <= 1'b1;
    end else begin
      r_rx_meta <= RX_IN;
      r_rx_s    <= r_rx_meta;
      r_rx_s_d  <= r_rx_s;
    end
  end

  // The edge-detect cycle is clock 0 of the start bit, so the counter is
  // loaded with 1 to keep edge_cnt aligned with the position inside the bit.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_edge_cnt <= '0;
    end else if (i_start) begin
      r_edge_cnt <= CNT_W'(1);
    end else if (i_run) begin
      if (r_edge_cnt == CNT_W'(PRESCALE - 1)) begin
        r_edge_cnt <= '0;
      end else begin
        r_edge_cnt <= r_edge_cnt + CNT_W'(1);
      end
    end else begin
      r_edge_cnt <= '0;
    end
  end

  assign o_fall    = r_rx_s_d & ~r_rx_s;
  assign o_bit_end = i_run && (r_edge_cnt == CNT_W'(PRESCALE - 1));

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic r_smp_a;
  logic r_smp_b;

  // Hold the two earlier samples; the third is the live line at the strobe.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_smp_a <= 1'b1;
      r_smp_b <= 1'b1;
    end else begin
      if (r_edge_cnt == CNT_W'(PRESCALE / 2 - 1)) r_smp_a <= r_rx_s;
      if (r_edge_cnt == CNT_W'(PRESCALE / 2))     r_smp_b <= r_rx_s;
    end
  end

  assign o_bit_strobe = i_run && (r_edge_cnt == CNT_W'(PRESCALE / 2 + 1));
  assign o_bit_val    = (r_smp_a & r_smp_b) | (r_smp_a & r_rx_s) | (r_smp_b & r_rx_s);
`else
  assign o_bit_strobe = i_run && (r_edge_cnt == CNT_W'(PRESCALE / 2));
  assign o_bit_val    = r_rx_s;
`endif

endmodule

// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer: UART receiver. Rebuilds start / DATA_WIDTH data bits
// (LSB first) / optional parity / stop frames from the oversampled line.
//   CLK, RST    clock, synchronous active-high reset
//   RX_IN       serial line, idle high, asynchronous to CLK
//   PAR_EN      parity bit present (latched at start detection)
//   PAR_TYP     0 = even, 1 = odd (latched at start detection)
//   P_DATA      last good received word, held until the next good frame
//   Data_valid  1-cycle pulse, P_DATA updated
//   par_err     1-cycle pulse, parity mismatch with a good stop bit
//   stp_err     1-cycle pulse, stop bit sampled low
// Build option: UART_RX_MAJORITY_VOTE_EN (see uart_rx_sampler).
module uart_rx_deframer
  import uart_pkg::*;
#(
  parameter int unsigned PRESCALE   = 8,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  Data_valid,
  output logic                  par_err,
  output logic                  stp_err
);

  localparam int unsigned BCNT_W = $clog2(DATA_WIDTH + 1);

  rx_state_e             r_state;
  rx_state_e             w_state_nxt;
  logic [DATA_WIDTH-1:0] r_shreg;
  logic [BCNT_W-1:0]     r_bit_cnt;
  logic                  r_par_en;
  logic                  r_par_typ;
  logic                  r_par_bad;
  logic [DATA_WIDTH-1:0] r_p_data;
  logic                  r_data_valid;
  logic                  r_par_err;
  logic                  r_stp_err;

  logic w_fall;
  logic w_bit_val;
  logic w_bit_strobe;
  logic w_bit_end;
  logic w_start;
  logic w_run;
  logic w_dv_nxt;
  logic w_pe_nxt;
  logic w_se_nxt;

  uart_rx_sampler #(
    .PRESCALE(PRESCALE)
  ) u_sampler (
    .CLK         (CLK),
    .RST         (RST),
    .RX_IN       (RX_IN),
    .i_start     (w_start),
    .i_run       (w_run),
    .o_fall      (w_fall),
    .o_bit_val   (w_bit_val),
    .o_bit_strobe(w_bit_strobe),
    .o_bit_end   (w_bit_end)
  );

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic. STOP leaves at the sample point so a start bit that
  // follows with no idle gap is still seen as a fresh falling edge.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:   if (w_fall) w_state_nxt = START;
      START: begin
        if (w_bit_strobe && w_bit_val) w_state_nxt = IDLE;
        else if (w_bit_end)            w_state_nxt = DATA;
      end
      DATA: begin
        if (w_bit_end && (r_bit_cnt == BCNT_W'(DATA_WIDTH))) begin
          w_state_nxt = r_par_en ? PARITY : STOP;
        end
      end
      PARITY: if (w_bit_end) w_state_nxt = STOP;
      STOP:   if (w_bit_strobe) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output/control decode; at most one of the three result pulses per frame.
  always_comb begin
    w_start  = 1'b0;
    w_run    = 1'b0;
    w_dv_nxt = 1'b0;
    w_pe_nxt = 1'b0;
    w_se_nxt = 1'b0;
    w_start  = (r_state == IDLE) && w_fall;
    w_run    = (r_state != IDLE);
    if ((r_state == STOP) && w_bit_strobe) begin
      w_dv_nxt =  w_bit_val && !r_par_bad;
      w_pe_nxt =  w_bit_val &&  r_par_bad;
      w_se_nxt = !w_bit_val;
    end
  end

  // Frame datapath: parity config, shift register, bit count, parity flag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_shreg   <= '0;
      r_bit_cnt <= '0;
      r_par_en  <= 1'b0;
      r_par_typ <= PAR_EVEN;
      r_par_bad <= 1'b0;
    end else begin
      if (w_start) begin
        r_bit_cnt <= '0;
        r_par_en  <= PAR_EN;
        r_par_typ <= PAR_TYP;
        r_par_bad <= 1'b0;
      end
      // Shifting in from the top leaves the first (LSB) bit at index 0.
      if ((r_state == DATA) && w_bit_strobe) begin
        r_shreg   <= {w_bit_val, r_shreg[DATA_WIDTH-1:1]};
        r_bit_cnt <= r_bit_cnt + BCNT_W'(1);
      end
      if ((r_state == PARITY) && w_bit_strobe) begin
        r_par_bad <= (w_bit_val != par_calc(UART_PAR_W'(r_shreg), r_par_typ));
      end
    end
  end

  // Registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_p_data     <= '0;
      r_data_valid <= 1'b0;
      r_par_err    <= 1'b0;
      r_stp_err    <= 1'b0;
    end else begin
      r_data_valid <= w_dv_nxt;
      r_par_err    <= w_pe_nxt;
      r_stp_err    <= w_se_nxt;
      if (w_dv_nxt) r_p_data <= r_shreg;
    end
  end

  assign P_DATA     = r_p_data;
  assign Data_valid = r_data_valid;
  assign par_err    = r_par_err;
  assign stp_err    = r_stp_err;

endmodule
